regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb.sv | 130 +++++++++++++
 tb/tb_regfile_wb_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arb.sv
// Arbitrates the single register-file write port between pipeline writeback and a
// two-entry queue of multi-cycle unit results, with an anti-starvation force for aux.
module regfile_wb_arb #(
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_no,
   input  logic [31:0] wb_data,
   output logic        wb_stall,
   input  logic        aux_valid,
   output logic        aux_ready,
   input  logic [4:0]  aux_no,
   input  logic [31:0] aux_data,
   output logic        reg_write,
   output logic [4:0]  reg_no_in,
   output logic [31:0] reg_data_in,
   output logic [31:0] busy_mask
);

   typedef enum logic [1:0] {GNT_IDLE, GNT_WB, GNT_AUX} grant_t;

   localparam logic [1:0] DEPTH_C   = 2'(FIFO_DEPTH);
   localparam logic [1:0] STARVE_LD = 2'(STARVE_MAX);

   logic [1:0]  count;
   logic [1:0]  starve_left;
   logic [4:0]  slot_no   [2];
   logic [31:0] slot_data [2];
   logic        out_is_aux;
   grant_t      grant;
   logic        wb_req;
   logic        fifo_ne;
   logic        forced;
   logic        push;
   logic        pop;

   // starve_left counts down the WB wins still allowed while aux waits; zero forces aux.
   assign wb_req    = wb_valid && (wb_no != 5'd0);
   assign fifo_ne   = (count != 2'd0);
   assign forced    = fifo_ne && (starve_left == 2'd0);
   assign aux_ready = (count < DEPTH_C) && !rst;
   assign wb_stall  = forced && wb_req && !rst;
   assign push      = aux_valid && aux_ready && (aux_no != 5'd0);
   assign pop       = (grant == GNT_AUX);

   always_comb begin
      grant = GNT_IDLE;
      if (forced)
         grant = GNT_AUX;
      else if (wb_req)
         grant = GNT_WB;
      else if (fifo_ne)
         grant = GNT_AUX;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= 2'd0;
         starve_left <= STARVE_LD;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         if ((grant == GNT_WB) && fifo_ne)
            starve_left <= starve_left - 2'd1;
         else if ((grant == GNT_AUX) || !fifo_ne)
            starve_left <= STARVE_LD;
      end
   end

   // Slot 0 is always the head; a pop shifts slot 1 down, and a push lands behind it.
   always_ff @(posedge clk) begin
      if (pop) begin
         slot_no[0]   <= slot_no[1];
         slot_data[0] <= slot_data[1];
      end
      if (push) begin
         if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
            slot_no[0]   <= aux_no;
            slot_data[0] <= aux_data;
         end else begin
            slot_no[1]   <= aux_no;
            slot_data[1] <= aux_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write   <= 1'b0;
         reg_no_in   <= 5'd0;
         reg_data_in <= 32'd0;
         out_is_aux  <= 1'b0;
      end else begin
         reg_write  <= (grant != GNT_IDLE);
         out_is_aux <= (grant == GNT_AUX);
         case (grant)
            GNT_WB: begin
               reg_no_in   <= wb_no;
               reg_data_in <= wb_data;
            end
            GNT_AUX: begin
               reg_no_in   <= slot_no[0];
               reg_data_in <= slot_data[0];
            end
            default: begin
               reg_no_in   <= reg_no_in;
               reg_data_in <= reg_data_in;
            end
         endcase
      end
   end

   // A register stays busy until its aux write has left the output stage.
   always_comb begin
      busy_mask = 32'd0;
      if (count != 2'd0)
         busy_mask[slot_no[0]] = 1'b1;
      if (count == 2'd2)
         busy_mask[slot_no[1]] = 1'b1;
      if (reg_write && out_is_aux)
         busy_mask[reg_no_in] = 1'b1;
   end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios then random traffic, all checked
// against a queue-based model of the arbitration rules.
module tb_regfile_wb_arb;

   localparam int STARVE_MAX = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_no;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        aux_valid;
   logic        aux_ready;
   logic [4:0]  aux_no;
   logic [31:0] aux_data;
   logic        reg_write;
   logic [4:0]  reg_no_in;
   logic [31:0] reg_data_in;
   logic [31:0] busy_mask;

   int vectors     = 0;
   int miscompares = 0;
   int n_checks    = 0;
   int stall_seen  = 0;
   int write_seen  = 0;

   logic [4:0]  q_no[$];
   logic [31:0] q_data[$];
   int          m_starve = 0;
   logic        m_we     = 1'b0;
   logic        m_aux    = 1'b0;
   logic [4:0]  m_no     = 5'd0;
   logic [31:0] m_data   = 32'd0;

   regfile_wb_arb #(.FIFO_DEPTH(2), .STARVE_MAX(STARVE_MAX)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_no       (wb_no),
      .wb_data     (wb_data),
      .wb_stall    (wb_stall),
      .aux_valid   (aux_valid),
      .aux_ready   (aux_ready),
      .aux_no      (aux_no),
      .aux_data    (aux_data),
      .reg_write   (reg_write),
      .reg_no_in   (reg_no_in),
      .reg_data_in (reg_data_in),
      .busy_mask   (busy_mask)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_busy();
      logic [31:0] b;
      b = 32'd0;
      foreach (q_no[i]) b[q_no[i]] = 1'b1;
      if (m_we && m_aux) b[m_no] = 1'b1;
      return b;
   endfunction

   // One clock: drive, check combinational outputs, advance model, check registered outputs.
   task automatic step(input logic wv, input logic [4:0] wn, input logic [31:0] wd,
                       input logic av, input logic [4:0] an, input logic [31:0] ad,
                       input logic r);
      logic exp_ready, exp_stall, wb_req, forced, nonempty;
      int   grant;
      wb_valid = wv; wb_no = wn; wb_data = wd;
      aux_valid = av; aux_no = an; aux_data = ad;
      rst = r;
      #1;
      wb_req    = wv && (wn != 5'd0);
      nonempty  = (q_no.size() != 0);
      forced    = nonempty && (m_starve == STARVE_MAX);
      exp_ready = !r && (q_no.size() < 2);
      exp_stall = !r && forced && wb_req;
      chk("aux_ready", 32'(aux_ready), 32'(exp_ready));
      chk("wb_stall", 32'(wb_stall), 32'(exp_stall));
      if (wb_stall === 1'b1) stall_seen++;
      @(posedge clk);
      if (r) begin
         q_no.delete();
         q_data.delete();
         m_starve = 0;
         m_we = 1'b0; m_aux = 1'b0; m_no = 5'd0; m_data = 32'd0;
      end else begin
         if (forced)        grant = 2;
         else if (wb_req)   grant = 1;
         else if (nonempty) grant = 2;
         else               grant = 0;
         if (grant == 1 && nonempty)      m_starve = m_starve + 1;
         else if (grant == 2 || !nonempty) m_starve = 0;
         if (grant == 1) begin
            m_we = 1'b1; m_aux = 1'b0; m_no = wn; m_data = wd;
         end else if (grant == 2) begin
            m_we = 1'b1; m_aux = 1'b1;
            m_no = q_no.pop_front();
            m_data = q_data.pop_front();
         end else begin
            m_we = 1'b0; m_aux = 1'b0;
         end
         if (exp_ready && av && (an != 5'd0)) begin
            q_no.push_back(an);
            q_data.push_back(ad);
         end
      end
      vectors++;
      #1;
      chk("reg_write", 32'(reg_write), 32'(m_we));
      chk("reg_no_in", 32'(reg_no_in), 32'(m_no));
      chk("reg_data_in", reg_data_in, m_data);
      chk("busy_mask", busy_mask, model_busy());
      if (reg_write === 1'b1) write_seen++;
      @(negedge clk);
   endtask

   task automatic idle(input logic r);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r);
   endtask

   initial begin
      logic       wv, av, r;
      logic [4:0] wn, an;

      rst = 1'b1; wb_valid = 1'b0; wb_no = 5'd0; wb_data = 32'd0;
      aux_valid = 1'b0; aux_no = 5'd0; aux_data = 32'd0;
      idle(1'b1);
      idle(1'b1);
      chk("rst_busy", busy_mask, 32'd0);

      // V1: plain writeback, one-cycle latency
      step(1'b1, 5'd5, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("v1_we", 32'(reg_write), 32'd1);
      chk("v1_no", 32'(reg_no_in), 32'd5);
      chk("v1_data", reg_data_in, 32'hA5A5_A5A5);
      chk("v1_busy", busy_mask, 32'd0);
      idle(1'b0);

      // V2: single aux push with WB idle
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11, 1'b0);
      chk("v2_busy_k", busy_mask, 32'h80);
      chk("v2_we_k", 32'(reg_write), 32'd0);
      idle(1'b0);
      chk("v2_we", 32'(reg_write), 32'd1);
      chk("v2_no", 32'(reg_no_in), 32'd7);
      chk("v2_data", reg_data_in, 32'h11);
      chk("v2_busy_out", busy_mask, 32'h80);
      idle(1'b0);
      chk("v2_busy_clr", busy_mask, 32'd0);

      // V3: aux starved by continuous WB, forced through once per entry
      stall_seen = 0;
      for (int i = 0; i < 9; i++)
         step(1'b1, 5'(i + 1), $urandom, (i < 3), 5'(9 + i), $urandom, 1'b0);
      chk("v3_stalls", 32'(stall_seen), 32'd2);
      chk("v3_last_no", 32'(reg_no_in), 32'd10);
      idle(1'b0);

      // V4: register 0 requests are ignored on both sides
      write_seen = 0;
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'd0, $urandom, 1'b1, 5'd0, $urandom, 1'b0);
      chk("v4_writes", 32'(write_seen), 32'd0);
      chk("v4_ready", 32'(aux_ready), 32'd1);
      chk("v4_busy", busy_mask, 32'd0);

      // V5: reset with a full queue and partial starvation
      step(1'b1, 5'd3, $urandom, 1'b1, 5'd12, $urandom, 1'b0);
      step(1'b1, 5'd4, $urandom, 1'b1, 5'd13, $urandom, 1'b0);
      step(1'b1, 5'd6, $urandom, 1'b0, 5'd0, 32'd0, 1'b0);
      chk("v5_full", 32'(aux_ready), 32'd0);
      step(1'b1, 5'd8, $urandom, 1'b1, 5'd14, $urandom, 1'b1);
      chk("v5_busy", busy_mask, 32'd0);
      chk("v5_we", 32'(reg_write), 32'd0);
      idle(1'b0);
      chk("v5_busy_after", busy_mask, 32'd0);
      chk("v5_we_after", 32'(reg_write), 32'd0);

      // V6: simultaneous push and pop at one entry
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2020, 1'b0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'h2121, 1'b0);
      chk("v6_first", 32'(reg_no_in), 32'd20);
      chk("v6_busy", busy_mask, 32'h0030_0000);
      idle(1'b0);
      chk("v6_second", 32'(reg_no_in), 32'd21);
      chk("v6_data", reg_data_in, 32'h2121);
      idle(1'b0);

      for (int i = 0; i < 400; i++) begin
         wv = ($urandom_range(0, 3) != 0);
         wn = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         av = ($urandom_range(0, 1) != 0);
         an = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         r  = ($urandom_range(0, 49) == 0);
         step(wv, wn, $urandom, av, an, $urandom, r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
